// File: rtl/ta_mem_reader_if.sv
// ta_mem_reader_if: TA-state memory read port and beat output handshake of ta_mem_reader.
interface ta_mem_reader_if #(
    parameter int LANES      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 17,
    parameter int ADDR_WIDTH = 17
);
    logic [LANES-1:0]            mem_en;
    logic [LANES*ADDR_WIDTH-1:0] mem_addr;
    logic [LANES*DATA_WIDTH-1:0] mem_rdata;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES*DATA_WIDTH-1:0] out_data;
    logic [IDX_WIDTH-1:0]        out_clause;
    logic [IDX_WIDTH-1:0]        out_chunk;
    logic [LANES-1:0]            out_lane_mask;
    logic                        out_clause_last;
    logic                        out_last;
    modport master (
        output mem_en, mem_addr, out_valid, out_data, out_clause, out_chunk,
               out_lane_mask, out_clause_last, out_last,
        input  mem_rdata, out_ready
    );
    modport slave (
        input  mem_en, mem_addr, out_valid, out_data, out_clause, out_chunk,
               out_lane_mask, out_clause_last, out_last,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/ta_mem_reader.sv
// ta_mem_reader: sweeps every (clause, chunk group) of the TA-state memory and streams tagged beats.
// Defining TA_RD_PERF_EN builds the stall_cycles backpressure counter; otherwise it reads 0.
module ta_mem_reader #(
    parameter int CLAUSES    = 2000,
    parameter int LA_CHUNKS  = 49,
    parameter int LANES      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 17,
    parameter int ADDR_WIDTH = 17
) (
    input  logic        clk,
    input  logic        rst_flag,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] stall_cycles,
    ta_mem_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
    typedef struct packed {
        logic [LANES*DATA_WIDTH-1:0] data;
        logic [IDX_WIDTH-1:0]        clause;
        logic [IDX_WIDTH-1:0]        chunk;
        logic [LANES-1:0]            mask;
        logic                        clause_last;
        logic                        last;
    } beat_t;
    state_e           state_q, state_d;
    logic [IDX_WIDTH-1:0] clause_q, chunk_q;
    logic [1:0]       cnt_q;
    logic             rp_q, wp_q, inflight_q, done_q;
    beat_t            meta_q, head, wr_beat;
    beat_t            fifo_q [2];
    logic [LANES-1:0] mask;
    logic             grp_last, sweep_last, issue, pop, push, accept;
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            mask[i] = 32'(chunk_q) + i < LA_CHUNKS;
            bus.mem_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = issue ? ADDR_WIDTH'(32'(clause_q) * LA_CHUNKS + 32'(chunk_q) + i) : '0;
        end
    end
    assign grp_last   = 32'(chunk_q) + LANES >= LA_CHUNKS;
    assign sweep_last = grp_last && 32'(clause_q) == CLAUSES - 1;
    assign head       = fifo_q[rp_q];
    assign pop        = bus.out_valid && bus.out_ready;
    assign push       = inflight_q;
    assign accept     = state_q == IDLE && start && !abort;
    // Counting the in-flight read against the 2-entry buffer means a stalled consumer can never overflow it
    assign issue      = state_q == RUN && !abort && cnt_q + {1'b0, inflight_q} < 2'd2;
    assign bus.mem_en          = issue ? mask : '0;
    assign bus.out_valid       = cnt_q != 2'd0;
    assign bus.out_data        = head.data;
    assign bus.out_clause      = head.clause;
    assign bus.out_chunk       = head.chunk;
    assign bus.out_lane_mask   = head.mask;
    assign bus.out_clause_last = head.clause_last;
    assign bus.out_last        = head.last;
    assign busy = state_q != IDLE;
    assign done = done_q;
    always_comb begin
        wr_beat = meta_q;
        for (int i = 0; i < LANES; i++)
            wr_beat.data[i*DATA_WIDTH +: DATA_WIDTH] = meta_q.mask[i] ? bus.mem_rdata[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
    always_comb begin
        state_d = abort ? IDLE :
                  state_q == IDLE ? (start ? RUN : IDLE) :
                  state_q == RUN ? (issue && sweep_last ? DRAIN : RUN) :
                  (pop && head.last ? IDLE : DRAIN);
    end
    always_ff @(posedge clk or posedge rst_flag) begin
        if (rst_flag) begin
            state_q    <= IDLE;
            clause_q   <= '0;
            chunk_q    <= '0;
            cnt_q      <= '0;
            rp_q       <= 1'b0;
            wp_q       <= 1'b0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            meta_q     <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= !abort && state_q == DRAIN && pop && head.last;
            if (abort || accept) begin
                clause_q <= '0;
                chunk_q  <= '0;
            end else if (issue) begin
                chunk_q  <= grp_last ? '0 : chunk_q + IDX_WIDTH'(LANES);
                clause_q <= !grp_last ? clause_q : sweep_last ? '0 : clause_q + IDX_WIDTH'(1);
            end
            if (abort) begin
                cnt_q      <= '0;
                rp_q       <= 1'b0;
                wp_q       <= 1'b0;
                inflight_q <= 1'b0;
            end else begin
                inflight_q <= issue;
                if (issue)
                    meta_q <= '{'0, clause_q, chunk_q, mask, grp_last, sweep_last};
                if (push) begin
                    fifo_q[wp_q] <= wr_beat;
                    wp_q         <= !wp_q;
                end
                if (pop)
                    rp_q <= !rp_q;
                cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
            end
        end
    end
`ifdef TA_RD_PERF_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk or posedge rst_flag) begin
        if (rst_flag)
            stall_q <= '0;
        else if (accept)
            stall_q <= '0;
        else if (bus.out_valid && !bus.out_ready && stall_q != '1)
            stall_q <= stall_q + 32'd1;
    end
    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_ta_mem_reader.sv
// tb_ta_mem_reader: ta_mem_reader against a beat-list model of the sweep, with random backpressure,
// abort, reset and control-priority scenarios.
`timescale 1ns/1ps
module tb_ta_mem_reader;
    localparam int CL = 2, LA = 3, LN = 2, DW = 32, IW = 17, AW = 17;
    localparam int BW = LN*DW + 2*IW + LN + 2;
`ifdef TA_RD_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif
    logic        clk = 1'b0, rst_flag = 1'b1, start = 1'b0, abort = 1'b0;
    logic        busy, done;
    logic [31:0] stall_cycles;
    int          tests = 0, fails = 0, delivered = 0, outst = 0, done_cnt = 0;
    logic [31:0] model_stall = '0;
    logic [BW-1:0] exp_q [$];
    logic [BW-1:0] prev_beat = '0;
    logic        prev_hold = 1'b0, last_hs = 1'b0;

    ta_mem_reader_if #(.LANES(LN), .DATA_WIDTH(DW), .IDX_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();
    ta_mem_reader #(.CLAUSES(CL), .LA_CHUNKS(LA), .LANES(LN), .DATA_WIDTH(DW), .IDX_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_flag(rst_flag), .start(start), .abort(abort), .busy(busy), .done(done),
        .stall_cycles(stall_cycles), .bus(bus)
    );

    always #5 clk = ~clk;

    // Memory word = its address; disabled lanes return garbage so masking is exercised
    always @(posedge clk)
        for (int i = 0; i < LN; i++)
            bus.mem_rdata[i*DW +: DW] <= bus.mem_en[i] ? DW'(bus.mem_addr[i*AW +: AW]) : $urandom;

    function automatic logic [BW-1:0] cur_beat();
        return {bus.out_data, bus.out_clause, bus.out_chunk, bus.out_lane_mask, bus.out_clause_last, bus.out_last};
    endfunction

    function automatic void load_expected();
        exp_q.delete();
        delivered = 0;
        for (int c = 0; c < CL; c++)
            for (int ch = 0; ch < LA; ch += LN) begin
                logic [LN*DW-1:0] d = '0;
                logic [LN-1:0]    m = '0;
                for (int i = 0; i < LN; i++)
                    if (ch + i < LA) begin
                        m[i] = 1'b1;
                        d[i*DW +: DW] = DW'(c*LA + ch + i);
                    end
                exp_q.push_back({d, IW'(c), IW'(ch), m, ch + LN >= LA, ch + LN >= LA && c == CL - 1});
            end
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs just after the rising edge, return just after the falling edge
    task automatic cyc(input logic rdy, input logic st = 1'b0, input logic ab = 1'b0);
        @(posedge clk);
        #1 bus.out_ready = rdy;
        start = st;
        abort = ab;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_delivered(input int n);
        int k = 0;
        while (delivered < n && k < 50) begin
            cyc(1'b1);
            k++;
        end
        chk("beat_delivered", delivered >= n, 1);
    endtask

    task automatic wait_done(input int rnd);
        int k = 0;
        while (!done && k < 300) begin
            cyc(rnd != 0 ? 1'($urandom_range(0, 1)) : 1'b1);
            k++;
        end
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 0);
        chk("all_beats", exp_q.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mem_en"}, bus.mem_en, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_beat"}, cur_beat(), 0);
        chk({tag, "_stall"}, stall_cycles, 0);
    endtask

    initial begin : monitor
        logic hs;
        forever begin
            @(negedge clk);
            if (rst_flag) begin
                prev_hold = 1'b0;
                last_hs = 1'b0;
                outst = 0;
                model_stall = '0;
            end else begin
                chk("stall_cycles", stall_cycles, PERF != 0 ? model_stall : 32'd0);
                if (done)
                    chk("done_after_last", last_hs, 1);
                if (prev_hold) begin
                    chk("hold_valid", bus.out_valid, 1);
                    chk("hold_beat", cur_beat(), prev_beat);
                end
                if (bus.mem_en != '0)
                    chk("outstanding", outst < 2, 1);
                hs = bus.out_valid && bus.out_ready && !abort;
                if (hs) begin
                    chk("beat_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0)
                        chk("beat", cur_beat(), exp_q.pop_front());
                    delivered++;
                end
                last_hs = hs && bus.out_last;
                prev_hold = bus.out_valid && !bus.out_ready && !abort;
                prev_beat = cur_beat();
                done_cnt += int'(done);
                outst = abort ? 0 : outst + int'(bus.mem_en != '0) - int'(hs);
                if (!busy && start && !abort)
                    model_stall = '0;
                else if (bus.out_valid && !bus.out_ready && model_stall != '1)
                    model_stall++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d, k;
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1 check_zero("reset");
        @(posedge clk);
        #1 rst_flag = 1'b0;
        @(negedge clk);
        #1;
        // Model pinned against hand-computed beats
        load_expected();
        chk("model_beat1", exp_q[0], {64'h00000001_00000000, 17'd0, 17'd0, 2'b11, 1'b0, 1'b0});
        chk("model_beat2", exp_q[1], {64'h00000000_00000002, 17'd0, 17'd2, 2'b01, 1'b1, 1'b0});
        chk("model_beat3", exp_q[2], {64'h00000004_00000003, 17'd1, 17'd0, 2'b11, 1'b0, 1'b0});
        chk("model_beat4", exp_q[3], {64'h00000000_00000005, 17'd1, 17'd2, 2'b01, 1'b1, 1'b1});
        // Plain sweep with latency checks
        cyc(1'b1, 1'b1);
        cyc(1'b1);
        chk("lat_busy", busy, 1);
        chk("lat_mem_en", bus.mem_en, 2'b11);
        chk("lat_mem_addr", bus.mem_addr, {17'd1, 17'd0});
        cyc(1'b1);
        chk("lat_no_valid", bus.out_valid, 0);
        cyc(1'b1);
        chk("lat_valid", bus.out_valid, 1);
        chk("lat_first_beat", cur_beat(), {64'h00000001_00000000, 17'd0, 17'd0, 2'b11, 1'b0, 1'b0});
        d = done_cnt;
        wait_done(0);
        repeat (3) cyc(1'b1);
        chk("done_once", done_cnt, d + 1);
        // Backpressure after the first beat
        load_expected();
        cyc(1'b1, 1'b1);
        wait_delivered(1);
        cyc(1'b0);
        cyc(1'b0);
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_beat2", cur_beat(), {64'h00000000_00000002, 17'd0, 17'd2, 2'b01, 1'b1, 1'b0});
        repeat (3) cyc(1'b0);
        wait_done(0);
        // Stall counter: exactly seven stalled cycles, then cleared by a new start
        load_expected();
        cyc(1'b0, 1'b1);
        k = 0;
        while (!bus.out_valid && k < 20) begin
            cyc(1'b0);
            k++;
        end
        chk("perf_valid", bus.out_valid, 1);
        repeat (6) cyc(1'b0);
        cyc(1'b1);
        chk("perf_seven", stall_cycles, PERF != 0 ? 32'd7 : 32'd0);
        wait_done(0);
        load_expected();
        cyc(1'b1, 1'b1);
        cyc(1'b1);
        chk("perf_cleared", stall_cycles, 0);
        wait_done(0);
        // Abort while beat 2 is presented
        load_expected();
        cyc(1'b1, 1'b1);
        wait_delivered(1);
        k = 0;
        do begin
            cyc(1'b0);
            k++;
        end while (!bus.out_valid && k < 20);
        chk("abort_beat2", cur_beat(), {64'h00000000_00000002, 17'd0, 17'd2, 2'b01, 1'b1, 1'b0});
        d = done_cnt;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1);
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (5) cyc(1'b1);
        chk("abort_no_done", done_cnt, d);
        chk("abort_idle_mem", bus.mem_en, 0);
        load_expected();
        cyc(1'b1, 1'b1);
        wait_done(0);
        // Asynchronous reset mid-sweep
        load_expected();
        cyc(1'b1, 1'b1);
        wait_delivered(1);
        @(posedge clk);
        #3 rst_flag = 1'b1;
        #1 check_zero("midrst");
        repeat (2) cyc(1'b1);
        @(posedge clk);
        #1 rst_flag = 1'b0;
        @(negedge clk);
        #1;
        load_expected();
        cyc(1'b1, 1'b1);
        wait_done(1);
        // start while busy is ignored; start+abort in IDLE stays IDLE
        load_expected();
        d = done_cnt;
        cyc(1'b1, 1'b1);
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1, 1'b1);
        wait_done(0);
        repeat (3) cyc(1'b1);
        chk("restart_ignored", done_cnt, d + 1);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1);
        chk("start_abort_busy", busy, 0);
        cyc(1'b1);
        chk("start_abort_busy2", busy, 0);
        chk("start_abort_mem", bus.mem_en, 0);
        // Randomized backpressure sweeps
        for (int r = 0; r < 6; r++) begin
            load_expected();
            cyc(1'($urandom_range(0, 1)), 1'b1);
            wait_done(1);
            repeat (int'($urandom_range(0, 3))) cyc(1'($urandom_range(0, 1)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
